// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, data LSB first, optional even parity, stop bit.
// All state, including every output, is registered on the falling edge of clk.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cyc_reg;
  logic [BIT_W-1:0]      bit_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  parity_reg;
  logic                  bit_end;

  // The next data bit is taken from the post-shift value so tx_out changes on the same edge.
  always_comb begin
    shift_next = shift_reg >> 1;
    bit_end    = (cyc_reg == CNT_LAST);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state_reg == IDLE) begin
        if (tx_valid) begin
          shift_reg  <= tx_data;
          parity_reg <= ^tx_data;
          cyc_reg    <= '0;
          bit_reg    <= '0;
          state_reg  <= START;
          tx_out     <= 1'b0;
          tx_ready   <= 1'b0;
          tx_busy    <= 1'b1;
        end
      end else if (!bit_end) begin
        cyc_reg <= cyc_reg + CNT_W'(1);
      end else begin
        cyc_reg <= '0;
        case (state_reg)
          START: begin
            state_reg <= DATA;
            tx_out    <= shift_reg[0];
          end
          DATA: begin
            shift_reg <= shift_next;
            if (bit_reg == BIT_LAST) begin
              bit_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                tx_out    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_out    <= 1'b1;
              end
            end else begin
              bit_reg <= bit_reg + BIT_W'(1);
              tx_out  <= shift_next[0];
            end
          end
          PARITY: begin
            state_reg <= STOP;
            tx_out    <= 1'b1;
          end
          STOP: begin
            state_reg <= IDLE;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance without parity, one with; outputs sampled on the rising edge.
// A frame-level model (bit list indexed by elapsed cycles / CLKS_PER_BIT) predicts every cycle.
`timescale 1ns/1ps
module tb_serial_tx;

  localparam int DW = 8;
  localparam int C  = 4;

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [11:0] bits;   // bit k = k-th bit placed on the line
    int         nbits;
  } frame_vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [1:0]    ready_w, out_w, busy_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit m_in   [2];
  int m_t    [2];
  int m_nb   [2];
  bit m_bits [2][12];
  bit m_done [2];

  frame_vec_t vecs [4];

  always #5 clk = ~clk;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[0]), .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(ready_w[1]), .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Advance instance i by one falling edge, using the inputs present at that edge.
  task automatic model_step(input int i);
    int ones;
    m_done[i] = 1'b0;
    if (reset) begin
      m_in[i] = 1'b0;
    end else if (m_in[i]) begin
      m_t[i]++;
      if (m_t[i] == m_nb[i] * C) begin
        m_in[i]   = 1'b0;
        m_done[i] = 1'b1;
      end
    end else if (tx_valid) begin
      ones = 0;
      m_bits[i][0] = 1'b0;
      for (int j = 0; j < DW; j++) begin
        m_bits[i][1+j] = tx_data[j];
        ones += int'(tx_data[j]);
      end
      m_nb[i] = DW + 2;
      if (i == 1) begin
        m_bits[i][DW+1] = (ones % 2) != 0;
        m_nb[i] = DW + 3;
      end
      m_bits[i][m_nb[i]-1] = 1'b1;
      m_in[i] = 1'b1;
      m_t[i]  = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit e_out;
      model_step(i);
      e_out = m_in[i] ? m_bits[i][m_t[i] / C] : 1'b1;
      chk($sformatf("dut%0d {out,ready,busy,done}", i),
          32'({out_w[i], ready_w[i], busy_w[i], done_w[i]}),
          32'({e_out, !m_in[i], m_in[i], m_done[i]}));
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && (m_in[0] || m_in[1]); n++) step();
  endtask

  task automatic check_frame(input frame_vec_t v);
    int f;
    f = v.nbits * C;
    wait_idle();
    tx_valid = 1'b1;
    tx_data  = v.data;
    step();
    tx_valid = 1'b0;
    chk($sformatf("frame %02h start bit", v.data), 32'(out_w[v.dut]), 32'(v.bits[0]));
    for (int k = 1; k <= f; k++) begin
      step();
      if (k < f)
        chk($sformatf("frame %02h cycle %0d {out,done}", v.data, k),
            32'({out_w[v.dut], done_w[v.dut]}), 32'({v.bits[k / C], 1'b0}));
      else
        chk($sformatf("frame %02h end {out,ready,done}", v.data),
            32'({out_w[v.dut], ready_w[v.dut], done_w[v.dut]}), 32'(3'b111));
    end
  endtask

  initial begin
    int first, second;
    bit chk_next;

    vecs[0] = '{0, 8'hA5, 12'h34A, 10};
    vecs[1] = '{1, 8'h07, 12'h60E, 11};
    vecs[2] = '{1, 8'h03, 12'h406, 11};
    vecs[3] = '{0, 8'h5A, 12'h2B4, 10};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    @(posedge clk);
    step();
    chk("reset state dut0", 32'({out_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
    reset = 1'b0;

    for (int n = 0; n < 10; n++) begin
      step();
      chk("idle dut0", 32'({out_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
      chk("idle dut1", 32'({out_w[1], ready_w[1], busy_w[1], done_w[1]}), 32'(4'b1100));
    end

    for (int v = 0; v < 3; v++) check_frame(vecs[v]);

    // Back-to-back with tx_valid held: one idle cycle, done pulses 41 cycles apart.
    wait_idle();
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    first    = -1;
    second   = -1;
    chk_next = 1'b0;
    for (int n = 0; n < 200 && second < 0; n++) begin
      step();
      if (chk_next) begin
        chk("b2b next start bit", 32'({out_w[0], busy_w[0]}), 32'(2'b01));
        chk_next = 1'b0;
      end
      if (done_w[0]) begin
        if (first < 0) begin
          first = cyc;
          chk("b2b idle cycle {out,ready}", 32'({out_w[0], ready_w[0]}), 32'(2'b11));
          tx_data  = 8'hFF;
          chk_next = 1'b1;
        end else begin
          second   = cyc;
          tx_valid = 1'b0;
        end
      end
    end
    chk("b2b done spacing", 32'(second - first), 32'd41);

    // A word offered only while busy must not be queued.
    wait_idle();
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    step();
    tx_valid = 1'b0;
    repeat (8) step();
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    repeat (10) step();
    tx_valid = 1'b0;
    tx_data  = '0;
    wait_idle();
    for (int n = 0; n < 10; n++) begin
      step();
      chk("no queued frame dut0", 32'({out_w[0], busy_w[0]}), 32'(2'b10));
      chk("no queued frame dut1", 32'({out_w[1], busy_w[1]}), 32'(2'b10));
    end

    // Reset 12 cycles into a frame, then a clean frame afterwards.
    wait_idle();
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    step();
    tx_valid = 1'b0;
    repeat (11) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort state dut0", 32'({out_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'(4'b1100));
    for (int n = 0; n < 5; n++) begin
      step();
      chk("no done after abort", 32'(done_w[0]), 32'd0);
    end
    check_frame(vecs[3]);

    // Random traffic with occasional resets, checked against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      tx_valid = ($urandom_range(0, 2) == 0);
      tx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 149) == 0);
      step();
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    wait_idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Framed serial transmitter. Accepts one DATA_WIDTH-bit word through a valid/ready handshake and shifts it out on a single line: start bit, data LSB first, optional even parity bit, stop bit. Each bit is held for CLKS_PER_BIT clock cycles. It is the sending end of the team's serial link. It is built from the same falling-edge register style as the rest of the sequential library and drives the line that the serial receiver samples.

## Interface
- DATA_WIDTH, 8: word width in bits, 1..16.
- CLKS_PER_BIT, 4: clock cycles per serial bit, ≥1.
- PARITY_EN, 0: 1 inserts an even-parity bit between the data bits and the stop bit.

- clk  input  1  clock; all state updates on the falling edge.
- reset  input  1  synchronous, active-high reset, sampled on the falling edge of clk.
- tx_valid  input  1  word on tx_data is offered.
- tx_data  input  DATA_WIDTH  word to send, captured at acceptance.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx_out  output  1  serial line; idle level 1.
- tx_busy  output  1  a frame is in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse at frame completion.

## Operation
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, bit counter 0, cycle counter 0, shift register 0.
- Acceptance: on a falling edge with tx_valid=1 and tx_ready=1, the block:
  - latches tx_data into the shift register;
  - computes parity as the XOR of tx_data;
  - moves to START, with tx_out=0, tx_ready=0, tx_busy=1.
- States:
  - IDLE: tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out = shift register bit 0; the register shifts right once per completed bit.
  - PARITY: tx_out = latched parity.
  - STOP: tx_out=1.
- The cycle counter runs from 0 to CLKS_PER_BIT-1 in every non-IDLE state. A state or bit advances only on the edge where the counter equals CLKS_PER_BIT-1, and the counter then wraps to 0.
- Transitions:
  - START→DATA.
  - DATA stays until DATA_WIDTH bits are sent, then goes to PARITY if PARITY_EN=1, else to STOP.
  - PARITY→STOP.
  - STOP→IDLE.
- Leaving STOP on an edge sets tx_done=1 for exactly that cycle, tx_ready=1, and tx_busy=0.
- tx_valid and tx_data are ignored while tx_ready=0. A word presented while busy is not queued.
- Reset mid-frame aborts the frame. At the reset edge all outputs take their reset values, with no tx_done pulse. The partial word is discarded.
- Reset has priority over acceptance on the same edge.
- CLKS_PER_BIT=1 is legal: one cycle per bit, no wrap stall.

## Timing
- tx_out goes low on the acceptance edge itself. The start bit occupies the following CLKS_PER_BIT cycles.
- Frame length: F = (2 + DATA_WIDTH + PARITY_EN) × CLKS_PER_BIT cycles, from the acceptance edge to the edge where tx_done rises.
- Data bit i (LSB = 0) is on tx_out for cycles (1+i)×CLKS_PER_BIT through (2+i)×CLKS_PER_BIT−1 after acceptance.
- Back-to-back: with tx_valid held high, the next acceptance happens on the edge after tx_done rises. This leaves exactly one idle cycle (tx_out=1) between the stop bit and the next start bit.
- tx_done and tx_ready rise on the same edge. tx_done falls on the next edge regardless of tx_valid.

## Test plan
- Reset, then idle 10 cycles -> tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 every cycle.
- DATA_WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0; send 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; tx_done pulses 40 cycles after acceptance.
- PARITY_EN=1; send 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity 1, then stop 1; frame 44 cycles. Send 0x03 -> parity 0.
- Back-to-back 0x00 then 0xFF with tx_valid held -> exactly one idle cycle at tx_out=1 between the frames; two tx_done pulses 41 cycles apart.
- tx_valid=1 with tx_data=0x3C asserted only mid-frame and dropped before IDLE -> no second frame; line stays 1 after the stop bit.
- Assert reset 12 cycles into a 0xA5 frame -> the next cycle shows tx_out=1, tx_ready=1, tx_busy=0, and no tx_done pulse; a following send of 0x5A transmits correctly.
